// File: rtl/mem_access_unit.sv
// Load/store initiator: one aligned byte/half/word access at a time against a
// word-organised memory, with read-modify-write for sub-word stores.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state_r, state_nxt_s;
   logic        we_r, unsigned_r;
   logic [1:0]  size_r, off_r;
   logic [31:0] wdata_r, rsp_rdata_r, mem_addr_r, mem_wdata_r;
   logic        rsp_err_r;
   logic        bad_s, word_store_s;

   function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = off[0];
         2'b10:   bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] size, input logic [1:0] off);
      logic [31:0] res;
      logic [4:0]  sh;
      res = word;
      sh  = {off, 3'b000};
      case (size)
         2'b00:   res[sh +: 8] = data[7:0];
         2'b01:   res[{off[1], 4'b0000} +: 16] = data[15:0];
         2'b10:   res = data;
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] extract_word(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
      logic [31:0] res;
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   res = {{24{~uns & b[7]}}, b};
         2'b01:   res = {{16{~uns & h[15]}}, h};
         2'b10:   res = word;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   assign bad_s        = bad_access(req_size, req_addr[1:0]);
   assign word_store_s = req_we && (req_size == 2'b10);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and strobe decode; strobes come from the state register only
   always_comb begin
      state_nxt_s = state_r;
      req_ready   = 1'b0;
      mem_ren     = 1'b0;
      mem_wen     = 1'b0;
      rsp_valid   = 1'b0;
      case (state_r)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (bad_s)             state_nxt_s = RESP;
               else if (word_store_s) state_nxt_s = WRITE;
               else                   state_nxt_s = READ;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         READ: begin
            mem_ren     = 1'b1;
            state_nxt_s = we_r ? WRITE : RESP;
         end
         WRITE: begin
            mem_wen     = 1'b1;
            state_nxt_s = RESP;
         end
         RESP: begin
            rsp_valid   = 1'b1;
            state_nxt_s = IDLE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Request latch, memory address/data and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_r        <= 1'b0;
         unsigned_r  <= 1'b0;
         size_r      <= 2'b00;
         off_r       <= 2'b00;
         wdata_r     <= 32'h0000_0000;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_err_r   <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  we_r        <= req_we;
                  unsigned_r  <= req_unsigned;
                  size_r      <= req_size;
                  off_r       <= req_addr[1:0];
                  wdata_r     <= req_wdata;
                  rsp_rdata_r <= 32'h0000_0000;
                  rsp_err_r   <= bad_s;
                  // Errored requests leave the memory-side registers untouched
                  if (!bad_s) begin
                     mem_addr_r <= {req_addr[31:2], 2'b00};
                     if (word_store_s) mem_wdata_r <= req_wdata;
                  end
               end
            end
            READ: begin
               if (we_r) mem_wdata_r <= merge_word(mem_rdata, wdata_r, size_r, off_r);
               else      rsp_rdata_r <= extract_word(mem_rdata, size_r, off_r, unsigned_r);
            end
            default: begin
            end
         endcase
      end
   end

   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a behavioural
// memory/transaction model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, mem_ren, mem_wen;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem     [16];
   logic [31:0] ref_mem [16];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory of 16 words at 0x100..0x13F: combinational read, negedge write
   assign mem_rdata = mem[mem_addr[5:2]];
   always @(negedge clk) if (mem_wen) mem[mem_addr[5:2]] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input int size, input int off, input logic uns);
      longint unsigned v;
      if (size == 2) return w;
      if (size == 0) begin
         v = (longint'(w) >> (8 * off)) & 64'hFF;
         if (!uns && v >= 64'd128) v = v + 64'hFFFF_FF00;
      end else begin
         v = (longint'(w) >> (8 * off)) & 64'hFFFF;
         if (!uns && v >= 64'd32768) v = v + 64'hFFFF_0000;
      end
      return v[31:0];
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d, input int size, input int off);
      logic [31:0] mask;
      if (size == 0)      mask = 32'h0000_00FF << (8 * off);
      else if (size == 1) mask = 32'h0000_FFFF << (8 * off);
      else                mask = 32'hFFFF_FFFF;
      return (w & ~mask) | ((d << (8 * off)) & mask);
   endfunction

   task automatic scramble();
      req_valid    = 1'b1;
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
      logic        err, got;
      int          idx, off, sz, exp_lat, exp_ren, exp_wen, cyc, nren, nwen;
      logic [31:0] exp_rd, new_w;
      idx = int'(addr[5:2]);
      off = int'(addr[1:0]);
      sz  = int'(size);
      err = (sz == 3) || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
      new_w  = ref_mem[idx];
      exp_rd = 32'h0000_0000;
      if (err) begin
         exp_lat = 1; exp_ren = 0; exp_wen = 0;
      end else if (!we) begin
         exp_lat = 2; exp_ren = 1; exp_wen = 0;
         exp_rd  = model_load(ref_mem[idx], sz, off, uns);
      end else begin
         new_w   = model_store(ref_mem[idx], wd, sz, off);
         exp_wen = 1;
         exp_ren = (sz == 2) ? 0 : 1;
         exp_lat = (sz == 2) ? 2 : 3;
      end
      @(negedge clk);
      chk("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      @(posedge clk);
      cyc = 0; nren = 0; nwen = 0; got = 1'b0;
      while (!got && cyc < 8) begin
         @(negedge clk);
         cyc++;
         chk("ready_busy", 32'(req_ready), 32'd0);
         if (mem_ren && mem_wen) chk("ren_wen_both", 32'd1, 32'd0);
         if (mem_ren) begin
            nren++;
            chk("ren_addr", mem_addr, {addr[31:2], 2'b00});
         end
         if (mem_wen) begin
            nwen++;
            chk("wen_addr", mem_addr, {addr[31:2], 2'b00});
            chk("wen_wdata", mem_wdata, new_w);
         end
         if (rsp_valid) begin
            got = 1'b1;
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_err", 32'(rsp_err), 32'(err));
         end
         scramble();
      end
      chk("latency", 32'(cyc), 32'(exp_lat));
      chk("ren_cycles", 32'(nren), 32'(exp_ren));
      chk("wen_cycles", 32'(nwen), 32'(exp_wen));
      ref_mem[idx] = new_w;
      chk("mem_word", mem[idx], ref_mem[idx]);
   endtask

   task automatic reset_during_write();
      int idx;
      idx = int'(4'h0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 32'h0000_0102; req_wdata = 32'h0000_5A5A;
      @(posedge clk);
      @(posedge clk);
      #1 chk("rst_wen_before", 32'(mem_wen), 32'd1);
      #1 rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("rst_wen_drop", 32'(mem_wen), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mem_kept", mem[idx], ref_mem[idx]);
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      chk("rst_ready_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i]     = 32'h0000_0000;
         ref_mem[i] = 32'h0000_0000;
      end
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      #2;
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_strobes", {30'd0, mem_ren, mem_wen}, 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      chk("reset_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_req(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1122_3344);
      do_req(1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h0000_00AA);
      chk("dir_merged", ref_mem[0], 32'h11AA_3344);
      do_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
      do_req(1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0);
      do_req(1'b0, 2'b00, 1'b1, 32'h0000_0102, 32'h0);
      do_req(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0);
      do_req(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1122_B344);
      do_req(1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0);
      do_req(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
      do_req(1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'hFFFF_FFFF);
      do_req(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
      reset_during_write();

      for (int n = 0; n < 300; n++) begin
         do_req(1'($urandom), 2'($urandom), 1'($urandom),
                32'h0000_0100 + $urandom_range(0, 63), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
